// File: rtl/frame_in.sv
// frame_in: byte-stream receiver for the 8-byte telemetry frame
//   HEAD, uid_hi, uid_lo, zid, cnt, type, rssi, TAIL
// The frame is hunted, collected into a shadow register, then checked
// against TAIL. Good frames update the output fields and pulse fvld_o.
// Discarded frames pulse ferr_o and bump a saturating error counter.
// Optional inter-byte timeout is compiled in with FRAME_IN_TIMEOUT_EN.
module frame_in #(
    parameter logic [7:0]  HEAD    = 8'hCA,
    parameter logic [7:0]  TAIL    = 8'hFE,
    parameter int unsigned TIMEOUT = 12000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  din_i,
    input  logic        dvld_i,
    output logic [15:0] uid_o,
    output logic [7:0]  zid_o,
    output logic [7:0]  cnt_o,
    output logic [7:0]  type_o,
    output logic [7:0]  rssi_o,
    output logic        fvld_o,
    output logic        ferr_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_CHECK
    } state_e;

    // Parameter range guard: the timeout counter is 16 bits wide.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("frame_in: TIMEOUT must be within 1..65535");
    end

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [47:0] shadow_q, shadow_d;
    logic [15:0] uid_q, uid_d;
    logic [7:0]  zid_q, zid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  type_q, type_d;
    logic [7:0]  rssi_q, rssi_d;
    logic        fvld_q, fvld_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  err_cnt_inc;
`ifdef FRAME_IN_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
`endif

    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Next-state, shadow capture, field update, error and timeout logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        uid_d     = uid_q;
        zid_d     = zid_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        rssi_d    = rssi_q;
        fvld_d    = 1'b0;
        ferr_d    = 1'b0;
        err_cnt_d = err_cnt_q;
`ifdef FRAME_IN_TIMEOUT_EN
        tmo_d     = '0;
`endif

        if (dvld_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (din_i == HEAD) begin
                        state_d = ST_BODY;
                        idx_d   = '0;
                    end
                end
                ST_BODY: begin
                    // Slot 0 lands in the top byte so the shadow reads uid..rssi.
                    for (int unsigned i = 0; i < 6; i++) begin
                        if (idx_q == 3'(i)) shadow_d[8*(5-i) +: 8] = din_i;
                    end
                    if (idx_q == 3'd5) begin
                        state_d = ST_CHECK;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                ST_CHECK: begin
                    if (din_i == TAIL) begin
                        uid_d   = shadow_q[47:32];
                        zid_d   = shadow_q[31:24];
                        cnt_d   = shadow_q[23:16];
                        type_d  = shadow_q[15:8];
                        rssi_d  = shadow_q[7:0];
                        fvld_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d    = 1'b1;
                        err_cnt_d = err_cnt_inc;
                        idx_d     = '0;
                        // A HEAD in the tail slot starts the next frame at once.
                        state_d   = (din_i == HEAD) ? ST_BODY : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
`ifdef FRAME_IN_TIMEOUT_EN
        else if (state_q != ST_IDLE) begin
            // Fires on the idle cycle that would bring the count to TIMEOUT;
            // a byte in that cycle takes the dvld_i branch instead.
            if ({1'b0, tmo_q} + 17'd1 == 17'(TIMEOUT)) begin
                ferr_d    = 1'b1;
                err_cnt_d = err_cnt_inc;
                state_d   = ST_IDLE;
                idx_d     = '0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
`endif
    end

    // State, shadow, output field and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            uid_q     <= '0;
            zid_q     <= '0;
            cnt_q     <= '0;
            type_q    <= '0;
            rssi_q    <= '0;
            fvld_q    <= 1'b0;
            ferr_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            uid_q     <= uid_d;
            zid_q     <= zid_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            rssi_q    <= rssi_d;
            fvld_q    <= fvld_d;
            ferr_q    <= ferr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef FRAME_IN_TIMEOUT_EN
    // Inter-byte idle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end
`endif

    assign uid_o     = uid_q;
    assign zid_o     = zid_q;
    assign cnt_o     = cnt_q;
    assign type_o    = type_q;
    assign rssi_o    = rssi_q;
    assign fvld_o    = fvld_q;
    assign ferr_o    = ferr_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_frame_in.sv
// Scoreboard bench for frame_in: a queue-based frame model predicts every
// fvld/ferr pulse; a monitor pops and compares each pulse as it appears.
module tb_frame_in;

    localparam logic [7:0]  HEAD = 8'hCA;
    localparam logic [7:0]  TAIL = 8'hFE;
    localparam int unsigned TO   = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic        dvld = 1'b0;
    logic [15:0] uid;
    logic [7:0]  zid, cnt, typ, rssi, err_cnt;
    logic        fvld, ferr;

    frame_in #(.HEAD(HEAD), .TAIL(TAIL), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .din_i(din), .dvld_i(dvld),
        .uid_o(uid), .zid_o(zid), .cnt_o(cnt), .type_o(typ), .rssi_o(rssi),
        .fvld_o(fvld), .ferr_o(ferr), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          good;
        logic [15:0] uid;
        logic [7:0]  zid, cnt, typ, rssi, ec;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  mbuf[$];        // bytes of the frame in progress, HEAD first
    logic [15:0] m_uid;
    logic [7:0]  m_zid, m_cnt, m_typ, m_rssi, m_ec;
    int          nchecks = 0;
    int          nerrs   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit good);
        exp_t e;
        e.good = good; e.uid = m_uid; e.zid = m_zid; e.cnt = m_cnt;
        e.typ = m_typ; e.rssi = m_rssi; e.ec = m_ec;
        expq.push_back(e);
    endtask

    task automatic model_err();
        if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
        push_exp(1'b0);
    endtask

    // Idle gap before a byte: a frame in progress dies after TO idle cycles.
    task automatic model_gap(input int gap);
`ifdef FRAME_IN_TIMEOUT_EN
        if (mbuf.size() > 0 && gap >= int'(TO)) begin
            model_err();
            mbuf.delete();
        end
`else
        if (gap < 0) $display("negative gap %0d", gap);
`endif
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (mbuf.size() == 0) begin
            if (b == HEAD) mbuf.push_back(b);
        end else if (mbuf.size() < 7) begin
            mbuf.push_back(b);
        end else begin
            if (b == TAIL) begin
                m_uid = {mbuf[1], mbuf[2]}; m_zid = mbuf[3]; m_cnt = mbuf[4];
                m_typ = mbuf[5]; m_rssi = mbuf[6];
                push_exp(1'b1);
                mbuf.delete();
            end else begin
                model_err();
                mbuf.delete();
                if (b == HEAD) mbuf.push_back(b);
            end
        end
    endtask

    task automatic model_reset();
        mbuf.delete();
        m_uid = '0; m_zid = '0; m_cnt = '0; m_typ = '0; m_rssi = '0; m_ec = '0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        model_gap(gap);
        model_byte(b);
        repeat (gap) begin
            @(negedge clk); dvld = 1'b0; din = 8'($urandom);
        end
        @(negedge clk); dvld = 1'b1; din = b;
    endtask

    task automatic idle(input int n);
        model_gap(n);
        repeat (n) begin
            @(negedge clk); dvld = 1'b0; din = '0;
        end
    endtask

    task automatic send_frame(input logic [7:0] f[8], input int gap);
        for (int i = 0; i < 8; i++) send(f[i], gap);
    endtask

    task automatic check_now(input string tag);
        idle(2);
        chk({tag, "_uid"}, uid, m_uid);
        chk({tag, "_zid"}, {8'h0, zid}, {8'h0, m_zid});
        chk({tag, "_cnt"}, {8'h0, cnt}, {8'h0, m_cnt});
        chk({tag, "_type"}, {8'h0, typ}, {8'h0, m_typ});
        chk({tag, "_rssi"}, {8'h0, rssi}, {8'h0, m_rssi});
        chk({tag, "_err_cnt"}, {8'h0, err_cnt}, {8'h0, m_ec});
        chk({tag, "_pending"}, 16'(expq.size()), 16'd0);
    endtask

    // Monitor: every output pulse must match the next predicted event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fvld && ferr) begin
                chk("fvld_ferr_overlap", {15'h0, fvld & ferr}, 16'h0);
            end else if (fvld || ferr) begin
                if (expq.size() == 0) begin
                    chk("unexpected_pulse_fvld", {15'h0, fvld}, 16'h0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("pulse_kind_fvld", {15'h0, fvld}, {15'h0, e.good});
                    chk("pulse_uid", uid, e.uid);
                    chk("pulse_zid", {8'h0, zid}, {8'h0, e.zid});
                    chk("pulse_cnt", {8'h0, cnt}, {8'h0, e.cnt});
                    chk("pulse_type", {8'h0, typ}, {8'h0, e.typ});
                    chk("pulse_rssi", {8'h0, rssi}, {8'h0, e.rssi});
                    chk("pulse_err_cnt", {8'h0, err_cnt}, {8'h0, e.ec});
                end
            end
        end
    end

    initial begin
        logic [7:0] good1[8];
        logic [7:0] cafe[8];
        logic [7:0] badt[8];
        logic [7:0] f[8];
        good1 = '{8'hCA, 8'h12, 8'h34, 8'h05, 8'h07, 8'h01, 8'h9C, 8'hFE};
        cafe  = '{8'hCA, 8'hCA, 8'hFE, 8'hCA, 8'hFE, 8'hCA, 8'hFE, 8'hFE};
        badt  = '{8'hCA, 8'h12, 8'h34, 8'h05, 8'h07, 8'h01, 8'h9C, 8'h00};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_now("reset");

        // Good frame with the widest gap that must not time out.
        send_frame(good1, int'(TO) - 1);
        check_now("good_slow");

        // Leading garbage, then a frame; HEAD/TAIL values as payload data.
        send(8'h00, 0); send(8'hFF, 0); send(8'hFE, 0);
        send_frame(good1, 0);
        send_frame(cafe, 1);
        check_now("garbage_cafe");

        // Bad tail leaves fields alone.
        send_frame(badt, 0);
        check_now("bad_tail");

        // HEAD in the tail slot starts the next frame.
        f = '{8'hCA, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'hCA};
        send_frame(f, 0);
        for (int i = 1; i < 8; i++) send(good1[i], 0);
        check_now("head_in_tail");

        // Timeout boundary: CA 12, then TO idle cycles before the rest.
        send(8'hCA, 0); send(8'h12, 0);
        for (int i = 2; i < 8; i++) send(good1[i], (i == 2) ? int'(TO) : 0);
        check_now("timeout");

        // Randomized frames: good, corrupted, truncated, with occasional long gaps.
        for (int n = 0; n < 150; n++) begin
            int unsigned kind;
            int unsigned len;
            kind = $urandom_range(0, 9);
            f[0] = HEAD; f[7] = TAIL;
            for (int i = 1; i < 7; i++) begin
                f[i] = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? HEAD : TAIL)
                                                  : 8'($urandom);
            end
            if (kind == 0) f[7] = 8'($urandom);
            if (kind == 1) f[$urandom_range(0, 7)] = 8'($urandom);
            len = (kind == 2) ? $urandom_range(1, 7) : 8;
            for (int unsigned i = 0; i < len; i++) begin
                int gap;
                gap = ($urandom_range(0, 24) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                                   : int'($urandom_range(0, 3));
                send(f[i], gap);
            end
        end
        check_now("random");

        // Error counter saturation.
        for (int n = 0; n < 300; n++) send_frame(badt, 0);
        check_now("saturate");

        // Reset mid-frame, then the remainder of the frame must be ignored.
        send(8'hCA, 0); send(8'h12, 0); send(8'h34, 0);
        @(negedge clk); dvld = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 3; i < 8; i++) send(good1[i], 0);
        check_now("reset_mid");

        for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 16'(expq.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/frame_in.md
# frame_in

Byte-stream frame receiver and parser: the far end of the 8-byte telemetry frame link. Consumes bytes qualified by a one-cycle strobe, hunts for the HEAD byte, collects the six payload bytes, checks the TAIL byte, and presents the decoded uid/zid/cnt/type/rssi fields with a one-cycle valid pulse. Malformed or stalled frames are discarded, flagged and counted. Sits between the byte-link front end and the host/data-logging logic.

## Interface
- `HEAD`, 8'hCA, frame start byte.
- `TAIL`, 8'hFE, frame end byte.
- `TIMEOUT`, 12000, maximum idle cycles between consecutive bytes of one frame. Range 1..65535.

- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `din` input 8: received byte.
- `dvld` input 1: `din` valid. One-cycle strobe per byte.
- `uid` output 16: uid of the last good frame. Byte 1 is [15:8].
- `zid` output 8: zid of the last good frame.
- `cnt` output 8: cnt of the last good frame.
- `type` output 8: type of the last good frame.
- `rssi` output 8: rssi of the last good frame.
- `fvld` output 1: one-cycle pulse when a good frame is latched.
- `ferr` output 1: one-cycle pulse when a frame is discarded.
- `err_cnt` output 8: count of discarded frames. Saturates at 255.

## Operation
- Frame layout: HEAD, uid_hi, uid_lo, zid, cnt, type, rssi, TAIL. Eight bytes, each carried by its own `dvld` strobe.
- Cycles with `dvld` low are ignored, apart from the timeout counter.

State machine:
- **IDLE**
  - `dvld` with `din`==HEAD: go to BODY, `idx`=0.
  - Any other byte: dropped silently. No `ferr`, no count.
- **BODY**
  - Each `dvld` stores `din` into a 48-bit shadow register at byte slot `idx` (0..5), then increments `idx`.
  - When the byte at `idx`==5 is stored, go to CHECK.
  - Payload bytes equal to HEAD or TAIL are plain data.
- **CHECK**
  - `dvld` with `din`==TAIL: copy shadow to the output fields, pulse `fvld`, go to IDLE.
  - `dvld` with `din`==HEAD: pulse `ferr`, increment `err_cnt`, go to BODY with `idx`=0. The mismatched byte is treated as the head of a new frame.
  - `dvld` with any other byte: pulse `ferr`, increment `err_cnt`, go to IDLE.

Other rules:
- Output fields change only on a good frame. Shadow contents from aborted frames are never visible.
- `err_cnt` saturates: an increment at 255 keeps 255.
- Timeout counter (16 bits):
  - Cleared on every `dvld`.
  - Increments each cycle in BODY/CHECK without `dvld`; held at 0 in IDLE.
  - Reaching `TIMEOUT` while in BODY/CHECK: pulse `ferr`, increment `err_cnt`, go to IDLE.
  - If `dvld` arrives in the same cycle the counter would reach `TIMEOUT`, the byte wins and no timeout fires.

## Timing
- Reset values: `uid`/`zid`/`cnt`/`type`/`rssi`=0, `fvld`=0, `ferr`=0, `err_cnt`=0, state IDLE, `idx`=0, timeout counter 0.
- Reset mid-frame discards the partial frame with no `ferr`.
- Latency: `fvld` and the new field values appear on the clock edge that samples the TAIL byte, i.e. they are visible in the cycle after the `dvld` cycle. Fields hold until the next good frame.
- `ferr` is registered with the same one-cycle latency. A timeout `ferr` asserts in the cycle after the counter reaches `TIMEOUT`.
- `fvld` and `ferr` are never high together.
- Back-to-back bytes on consecutive cycles are accepted: throughput is one byte per cycle.
- No backpressure: every `dvld` byte is consumed.

## Configuration
- `FRAME_IN_TIMEOUT_EN` defined: inter-byte timeout is compiled in as described above.
- `FRAME_IN_TIMEOUT_EN` undefined:
  - No timeout counter exists. `TIMEOUT` is unused.
  - A partial frame waits indefinitely for further bytes.
  - `ferr` arises only from a TAIL mismatch.

## Test plan
1. Good frame: CA 12 34 05 07 01 9C FE, spaced 6001 cycles apart -> one `fvld` pulse the cycle after FE; `uid`=16'h1234, `zid`=05, `cnt`=07, `type`=01, `rssi`=9C; `ferr` never high; `err_cnt`=0.
2. Leading garbage 00 FF FE, then the frame from test 1 -> same result as test 1 and `err_cnt`=0. Also send payload CA FE CA FE CA FE as data -> `uid`=16'hCAFE and the frame is accepted.
3. Bad tail: CA 12 34 05 07 01 9C 00 -> `ferr` pulse the cycle after 00; fields keep their previous values; `err_cnt`=1.
4. HEAD in the tail slot: CA 11 11 11 11 11 11 CA, then 12 34 05 07 01 9C FE -> one `ferr`, then `fvld` with `uid`=16'h1234. Also drive 300 bad frames -> `err_cnt` saturates at 255.
5. Timeout (macro on, `TIMEOUT`=100): CA 12, then 100 idle cycles -> `ferr` and `err_cnt`=1; following bytes 34..FE without a HEAD are ignored. Macro off: same stimulus, then 34 05 07 01 9C FE -> `fvld` with `uid`=16'h1234 and no `ferr`.
6. Reset mid-frame: assert `rst_n` low after CA 12 34, release, then send 05 07 01 9C FE -> all outputs 0, no `fvld`, no `ferr`.
